// File: rtl/decode_stage.sv
// decode_stage: instruction decoder with a 2-entry skid FIFO of decoded control bundles
module decode_stage #(
    parameter int RV64      = 1,
    parameter int EN_SYSTEM = 0,
    parameter int CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_flush,
    input  logic [31:0]      i_instr,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [2:0]       o_imm_src,
    output logic [2:0]       o_result_src,
    output logic [2:0]       o_alu_op,
    output logic             o_mem_we,
    output logic             o_reg_we,
    output logic             o_alu_src,
    output logic             o_branch,
    output logic             o_jump,
    output logic             o_load_instr,
    output logic [1:0]       o_forward_src,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [2:0]       o_funct3,
    output logic             o_funct7b5,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);
    typedef struct packed {
        logic [2:0] imm_src;
        logic [2:0] result_src;
        logic [2:0] alu_op;
        logic       mem_we;
        logic       reg_we;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       load_instr;
        logic [1:0] forward_src;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       funct7b5;
        logic       illegal;
    } dec_t;

    dec_t             dec;
    dec_t             head;
    dec_t             mem [2];
    logic             rp;
    logic             wp;
    logic [1:0]       cnt;
    logic [CNT_W-1:0] illegal_cnt;
    logic             push;
    logic             pop;

    assign o_valid = cnt != 2'd0;
    assign o_ready = cnt != 2'd2;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    // Decode the incoming word; full 7-bit opcode match also rejects instr[1:0] != 2'b11
    always_comb begin
        dec          = '0;
        dec.rd       = i_instr[11:7];
        dec.rs1      = i_instr[19:15];
        dec.rs2      = i_instr[24:20];
        dec.funct3   = i_instr[14:12];
        dec.funct7b5 = i_instr[30];
        case (i_instr[6:0])
            7'b0000011: begin
                dec.reg_we     = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 3'b001;
                dec.load_instr = 1'b1;
            end
            7'b0010011: begin
                dec.reg_we  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = 3'b010;
            end
            7'b1100111: begin
                dec.reg_we     = 1'b1;
                dec.alu_src    = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 3'b010;
            end
            7'b0011011: begin
                dec.reg_we  = RV64 != 0;
                dec.alu_src = RV64 != 0;
                dec.alu_op  = RV64 != 0 ? 3'b011 : 3'b000;
                dec.illegal = RV64 == 0;
            end
            7'b0100011: begin
                dec.mem_we  = 1'b1;
                dec.alu_src = 1'b1;
                dec.imm_src = 3'b001;
            end
            7'b0110011: begin
                dec.reg_we = 1'b1;
                dec.alu_op = 3'b010;
            end
            7'b0111011: begin
                dec.reg_we  = RV64 != 0;
                dec.alu_op  = RV64 != 0 ? 3'b011 : 3'b000;
                dec.illegal = RV64 == 0;
            end
            7'b1100011: begin
                dec.branch  = 1'b1;
                dec.alu_op  = 3'b001;
                dec.imm_src = 3'b010;
            end
            7'b1101111: begin
                dec.reg_we      = 1'b1;
                dec.jump        = 1'b1;
                dec.result_src  = 3'b010;
                dec.forward_src = 2'b01;
                dec.imm_src     = 3'b011;
            end
            7'b0010111: begin
                dec.reg_we      = 1'b1;
                dec.result_src  = 3'b011;
                dec.forward_src = 2'b01;
                dec.imm_src     = 3'b100;
            end
            7'b0110111: begin
                dec.reg_we      = 1'b1;
                dec.result_src  = 3'b100;
                dec.forward_src = 2'b10;
                dec.imm_src     = 3'b100;
            end
            7'b0001111, 7'b1110011: dec.illegal = EN_SYSTEM == 0;
            default:                dec.illegal = 1'b1;
        endcase
    end

    // Pointers, occupancy and the sticky illegal counter; flush clears the queue but not the counter
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            rp          <= 1'b0;
            wp          <= 1'b0;
            cnt         <= 2'd0;
            illegal_cnt <= '0;
        end else begin
            if (push && dec.illegal && illegal_cnt != {CNT_W{1'b1}})
                illegal_cnt <= illegal_cnt + 1'b1;
            if (i_flush) begin
                rp  <= 1'b0;
                wp  <= 1'b0;
                cnt <= 2'd0;
            end else begin
                wp  <= wp ^ push;
                rp  <= rp ^ pop;
                cnt <= cnt + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Entry storage needs no reset: it is only visible while occupancy says it is valid
    always_ff @(posedge i_clk) begin
        if (push && !i_flush)
            mem[wp] <= dec;
    end

    assign head          = o_valid ? mem[rp] : '0;
    assign o_imm_src     = head.imm_src;
    assign o_result_src  = head.result_src;
    assign o_alu_op      = head.alu_op;
    assign o_mem_we      = head.mem_we;
    assign o_reg_we      = head.reg_we;
    assign o_alu_src     = head.alu_src;
    assign o_branch      = head.branch;
    assign o_jump        = head.jump;
    assign o_load_instr  = head.load_instr;
    assign o_forward_src = head.forward_src;
    assign o_rd          = head.rd;
    assign o_rs1         = head.rs1;
    assign o_rs2         = head.rs2;
    assign o_funct3      = head.funct3;
    assign o_funct7b5    = head.funct7b5;
    assign o_illegal     = head.illegal;
    assign o_illegal_cnt = illegal_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage, default build plus an RV32 / 2-bit-counter build
module tb_decode_stage;
    logic i_clk = 1'b0;
    logic i_arstn = 1'b0;
    logic i_flush = 1'b0;
    logic [31:0] i_instr = '0;
    logic i_valid = 1'b0;
    logic i_ready = 1'b0;
    logic o_ready, o_valid, o_mem_we, o_reg_we, o_alu_src, o_branch, o_jump, o_load_instr, o_funct7b5, o_illegal;
    logic [2:0] o_imm_src, o_result_src, o_alu_op, o_funct3;
    logic [1:0] o_forward_src;
    logic [4:0] o_rd, o_rs1, o_rs2;
    logic [7:0] o_illegal_cnt;

    logic [31:0] a_instr = '0;
    logic a_valid = 1'b0;
    logic a_rdy_in = 1'b1;
    logic a_ready, a_ovalid, a_mem_we, a_reg_we, a_alu_src, a_branch, a_jump, a_load_instr, a_funct7b5, a_illegal;
    logic [2:0] a_imm_src, a_result_src, a_alu_op, a_funct3;
    logic [1:0] a_forward_src;
    logic [4:0] a_rd, a_rs1, a_rs2;
    logic [1:0] a_cnt;

    int total = 0;
    int passed = 0;
    logic [36:0] qm[$];
    logic [36:0] qa[$];

    wire [36:0] got = {o_imm_src, o_result_src, o_alu_op, o_mem_we, o_reg_we, o_alu_src, o_branch, o_jump,
                       o_load_instr, o_forward_src, o_rd, o_rs1, o_rs2, o_funct3, o_funct7b5, o_illegal};
    wire [36:0] a_got = {a_imm_src, a_result_src, a_alu_op, a_mem_we, a_reg_we, a_alu_src, a_branch, a_jump,
                         a_load_instr, a_forward_src, a_rd, a_rs1, a_rs2, a_funct3, a_funct7b5, a_illegal};

    decode_stage dut (
        .i_clk(i_clk), .i_arstn(i_arstn), .i_flush(i_flush), .i_instr(i_instr), .i_valid(i_valid),
        .o_ready(o_ready), .i_ready(i_ready), .o_valid(o_valid), .o_imm_src(o_imm_src),
        .o_result_src(o_result_src), .o_alu_op(o_alu_op), .o_mem_we(o_mem_we), .o_reg_we(o_reg_we),
        .o_alu_src(o_alu_src), .o_branch(o_branch), .o_jump(o_jump), .o_load_instr(o_load_instr),
        .o_forward_src(o_forward_src), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct3(o_funct3),
        .o_funct7b5(o_funct7b5), .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
    );

    decode_stage #(.RV64(0), .EN_SYSTEM(0), .CNT_W(2)) alt (
        .i_clk(i_clk), .i_arstn(i_arstn), .i_flush(1'b0), .i_instr(a_instr), .i_valid(a_valid),
        .o_ready(a_ready), .i_ready(a_rdy_in), .o_valid(a_ovalid), .o_imm_src(a_imm_src),
        .o_result_src(a_result_src), .o_alu_op(a_alu_op), .o_mem_we(a_mem_we), .o_reg_we(a_reg_we),
        .o_alu_src(a_alu_src), .o_branch(a_branch), .o_jump(a_jump), .o_load_instr(a_load_instr),
        .o_forward_src(a_forward_src), .o_rd(a_rd), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_funct3(a_funct3),
        .o_funct7b5(a_funct7b5), .o_illegal(a_illegal), .o_illegal_cnt(a_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected bundle: controls are hand-chosen; register fields are the raw instruction slices
    function automatic logic [36:0] ex(input logic [2:0] imm, input logic [2:0] res, input logic [2:0] alu,
                                       input logic [5:0] fl, input logic [1:0] fwd, input logic ill,
                                       input logic [31:0] w);
        return {imm, res, alu, fl, fwd, w[11:7], w[19:15], w[24:20], w[14:12], w[30], ill};
    endfunction

    function automatic logic [36:0] ill_ex(input logic [31:0] w);
        return ex(3'b000, 3'b000, 3'b000, 6'b000000, 2'b00, 1'b1, w);
    endfunction

    task automatic push_m(input logic [31:0] w, input logic [36:0] e);
        int n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!o_ready) chk("push_m_timeout", {63'd0, o_ready}, 64'd1);
        i_valid = 1'b1;
        i_instr = w;
        qm.push_back(e);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] w, input logic [36:0] e);
        a_valid = 1'b1;
        a_instr = w;
        qa.push_back(e);
        @(posedge i_clk);
        #1;
        a_valid = 1'b0;
    endtask

    // Monitors: compare the head against the scoreboard every cycle it is valid; pop on handshake
    always @(negedge i_clk) begin
        if (i_arstn && o_valid) begin
            if (qm.size() == 0) chk("main_unexpected", {27'd0, got}, 64'd0);
            else begin
                chk("main_head", {27'd0, got}, {27'd0, qm[0]});
                if (i_ready) void'(qm.pop_front());
            end
        end
    end

    always @(negedge i_clk) begin
        if (i_arstn && a_ovalid) begin
            if (qa.size() == 0) chk("alt_unexpected", {27'd0, a_got}, 64'd0);
            else begin
                chk("alt_head", {27'd0, a_got}, {27'd0, qa[0]});
                if (a_rdy_in) void'(qa.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] sat;
        #12;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_cnt", {56'd0, o_illegal_cnt}, 64'd0);
        chk("rst_outputs", {27'd0, got}, 64'd0);
        @(posedge i_clk);
        #1;
        i_arstn = 1'b1;
        i_ready = 1'b1;
        // addi x1, x0, 10: visible one cycle after acceptance
        push_m(32'h00A00093, ex(3'b000, 3'b000, 3'b010, 6'b011000, 2'b00, 1'b0, 32'h00A00093));
        chk("addi_latency", {63'd0, o_valid}, 64'd1);
        @(posedge i_clk);
        #1;
        // Back-to-back stream: push and pop together at occupancy 1
        push_m(32'h0000A103, ex(3'b000, 3'b001, 3'b000, 6'b011001, 2'b00, 1'b0, 32'h0000A103));
        push_m(32'h00000063, ex(3'b010, 3'b000, 3'b001, 6'b000100, 2'b00, 1'b0, 32'h00000063));
        push_m(32'h000010B7, ex(3'b100, 3'b100, 3'b000, 6'b010000, 2'b10, 1'b0, 32'h000010B7));
        push_m(32'h00000117, ex(3'b100, 3'b011, 3'b000, 6'b010000, 2'b01, 1'b0, 32'h00000117));
        push_m(32'h002081B3, ex(3'b000, 3'b000, 3'b010, 6'b010000, 2'b00, 1'b0, 32'h002081B3));
        push_m(32'h00008067, ex(3'b000, 3'b010, 3'b000, 6'b011010, 2'b00, 1'b0, 32'h00008067));
        push_m(32'h0000001B, ex(3'b000, 3'b000, 3'b011, 6'b011000, 2'b00, 1'b0, 32'h0000001B));
        push_m(32'h0000003B, ex(3'b000, 3'b000, 3'b011, 6'b010000, 2'b00, 1'b0, 32'h0000003B));
        push_m(32'h0000000F, ill_ex(32'h0000000F));
        push_m(32'h00000001, ill_ex(32'h00000001));
        repeat (2) @(posedge i_clk);
        #1;
        chk("stream_drained", {63'd0, o_valid}, 64'd0);
        chk("main_cnt_2", {56'd0, o_illegal_cnt}, 64'd2);
        // Backpressure: jal then sw fill the FIFO; jal must hold until i_ready
        i_ready = 1'b0;
        push_m(32'h0000006F, ex(3'b011, 3'b010, 3'b000, 6'b010010, 2'b01, 1'b0, 32'h0000006F));
        push_m(32'h00112023, ex(3'b001, 3'b000, 3'b000, 6'b101000, 2'b00, 1'b0, 32'h00112023));
        chk("full_not_ready", {63'd0, o_ready}, 64'd0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("jal_held", {61'd0, o_jump, o_result_src == 3'b010, o_mem_we}, 64'b110);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("sw_next", {59'd0, o_mem_we, o_imm_src, o_jump}, {59'd0, 1'b1, 3'b001, 1'b0});
        @(posedge i_clk);
        #1;
        chk("bp_drained", {63'd0, o_valid}, 64'd0);
        // Flush at occupancy 2 with a rejected illegal word on the input
        i_ready = 1'b0;
        push_m(32'h00A00093, ex(3'b000, 3'b000, 3'b010, 6'b011000, 2'b00, 1'b0, 32'h00A00093));
        push_m(32'h0000A103, ex(3'b000, 3'b001, 3'b000, 6'b011001, 2'b00, 1'b0, 32'h0000A103));
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_instr = 32'hFFFFFFFF;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        qm.delete();
        chk("flush_valid", {63'd0, o_valid}, 64'd0);
        chk("flush_ready", {63'd0, o_ready}, 64'd1);
        chk("flush_cnt_same", {56'd0, o_illegal_cnt}, 64'd2);
        // Flush from empty with an accepted illegal word: counted, never enqueued
        i_flush = 1'b1;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_accept_cnt", {56'd0, o_illegal_cnt}, 64'd3);
        chk("flush_accept_valid", {63'd0, o_valid}, 64'd0);
        // RV32 build with 2-bit counter
        push_a(32'h0000001B, ill_ex(32'h0000001B));
        chk("alt_w_illegal_cnt", {62'd0, a_cnt}, 64'd1);
        push_a(32'h0000003B, ill_ex(32'h0000003B));
        chk("alt_cnt_2", {62'd0, a_cnt}, 64'd2);
        for (int k = 3; k <= 6; k++) begin
            push_a(32'hFFFFFFFF, ill_ex(32'hFFFFFFFF));
            sat = 2'd3;
            chk("alt_cnt_sat", {62'd0, a_cnt}, {62'd0, sat});
        end
        repeat (2) @(posedge i_clk);
        #1;
        chk("alt_drained", {63'd0, a_ovalid}, 64'd0);
        // Asynchronous reset in the middle of a cycle with one entry held
        push_m(32'h00A00093, ex(3'b000, 3'b000, 3'b010, 6'b011000, 2'b00, 1'b0, 32'h00A00093));
        #2;
        i_arstn = 1'b0;
        #1;
        chk("async_valid", {63'd0, o_valid}, 64'd0);
        chk("async_cnt", {56'd0, o_illegal_cnt}, 64'd0);
        chk("async_ready", {63'd0, o_ready}, 64'd1);
        qm.delete();
        @(posedge i_clk);
        #1;
        i_arstn = 1'b1;
        i_ready = 1'b1;
        push_m(32'h002081B3, ex(3'b000, 3'b000, 3'b010, 6'b010000, 2'b00, 1'b0, 32'h002081B3));
        chk("post_rst_latency", {63'd0, o_valid}, 64'd1);
        repeat (3) @(posedge i_clk);
        #1;
        chk("qm_empty", 64'(qm.size()), 64'd0);
        chk("qa_empty", 64'(qa.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
